ysyx_22041412_ifu_axi_bridge: RTL and testbench

- Sits directly upstream of the instruction-fetch stage and serves its single-outstanding read request.
- Converts that request into one AXI4 read transaction (AR channel, then R channel) on the instruction master port.
- Selects the 32-bit instruction word from the 64-bit beat.
- Holds the response stable until the fetch stage acknowledges it, so a stalled fetch never loses an instruction.

---
 rtl/ysyx_22041412_axi_pkg.sv | 16 +
 rtl/ysyx_22041412_ifu_axi_bridge.sv | 139 +++++++++++++
 tb/tb_ysyx_22041412_ifu_axi_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared AXI constants and the IFU bridge state encoding.
package ysyx_22041412_axi_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;

    // IDLE: waiting for fetch; AR: address phase; R: data phase; HOLD: response parked for fetch
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_HOLD = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/ysyx_22041412_ifu_axi_bridge.sv
// Instruction-fetch to AXI4 read bridge: one single-beat read per fetch request,
// 32-bit word selected from the 64-bit beat, response held until the fetch acks it.
//
// Handshakes: every AXI channel transfers on a cycle where valid and ready are both
// high at the rising clock edge; a raised valid stays high with stable payload until
// that edge. On the fetch side, req_valid_i is held until rsp_valid_o is seen, and
// rsp_valid_o stays high with stable data/err until the one-cycle rsp_ack_i pulse.
module ysyx_22041412_ifu_axi_bridge
    import ysyx_22041412_axi_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 64,
    parameter logic [3:0] AXI_ID   = 4'd0,
    parameter int         WD_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    input  logic              rsp_ack_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [3:0]        arid_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic [3:0]        rid_i,
    output logic              wd_timeout_o,
    output bridge_state_e     state_o
);

    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    bridge_state_e   state_q;
    bridge_state_e   state_next;
    logic            word_sel_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            addr_aligned;

    // Single beat, single ID: last and ID carry no information here.
    logic unused_ok;
    assign unused_ok = ^{rlast_i, rid_i};

    assign addr_aligned = (req_addr_i[1:0] == 2'b00);

    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'd0;
    assign arsize_o  = SIZE_8B;
    assign arburst_o = BURST_INCR;
    assign state_o   = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_next;
    end

    // Next-state decode; misaligned requests skip the bus and go straight to HOLD.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) state_next = addr_aligned ? ST_AR : ST_HOLD;
            ST_AR:   if (arvalid_o && arready_i) state_next = ST_R;
            ST_R:    if (rvalid_i) state_next = ST_HOLD;
            ST_HOLD: if (rsp_ack_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus-side and response registers, plus the sticky R-channel watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= 32'd0;
            rsp_err_o    <= 1'b0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            araddr_o     <= '0;
            wd_timeout_o <= 1'b0;
            wd_cnt_q     <= '0;
            word_sel_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (addr_aligned) begin
                            word_sel_q <= req_addr_i[2];
                            araddr_o   <= {req_addr_i[ADDR_W-1:3], 3'b000};
                            arvalid_o  <= 1'b1;
                        end else begin
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= 32'd0;
                            rsp_valid_o <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (arvalid_o && arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        wd_cnt_q  <= '0;
                    end
                end
                ST_R: begin
                    if (rvalid_i) begin
                        rsp_data_o  <= word_sel_q ? rdata_i[63:32] : rdata_i[31:0];
                        rsp_err_o   <= (rresp_i != RESP_OKAY);
                        rready_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        // Flag on the cycle the count reaches the limit; AXI cannot abort,
                        // so the transaction keeps waiting for its beat.
                        if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
                        if (wd_cnt_q >= WD_LAST) wd_timeout_o <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ack_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_ifu_axi_bridge.sv
// Directed bench for the IFU AXI read bridge.
module tb_ysyx_22041412_ifu_axi_bridge;
    import ysyx_22041412_axi_pkg::*;

    localparam int WD_LIMIT = 255;

    logic          clk;
    logic          rst;
    logic          req_valid_i;
    logic [31:0]   req_addr_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_data_o;
    logic          rsp_err_o;
    logic          rsp_ack_i;
    logic          arvalid_o;
    logic          arready_i;
    logic [31:0]   araddr_o;
    logic [3:0]    arid_o;
    logic [7:0]    arlen_o;
    logic [2:0]    arsize_o;
    logic [1:0]    arburst_o;
    logic          rvalid_i;
    logic          rready_o;
    logic [63:0]   rdata_i;
    logic [1:0]    rresp_i;
    logic          rlast_i;
    logic [3:0]    rid_i;
    logic          wd_timeout_o;
    bridge_state_e state_o;

    int n_checks;
    int n_pass;
    int ar_hs;
    int ar_base;

    ysyx_22041412_ifu_axi_bridge #(
        .ADDR_W(32), .DATA_W(64), .AXI_ID(4'd0), .WD_LIMIT(WD_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .rsp_ack_i(rsp_ack_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rid_i(rid_i),
        .wd_timeout_o(wd_timeout_o), .state_o(state_o)
    );

    // Clock and AR handshake monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && arvalid_o && arready_i) ar_hs = ar_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive an aligned fetch through AR and R; leaves the bridge in HOLD.
    task automatic fetch(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] resp,
                         input int ar_wait, input logic [31:0] exp_araddr);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        tick();
        check("arvalid_rise", arvalid_o, 1);
        check("araddr", araddr_o, exp_araddr);
        check("rsp_valid_early", rsp_valid_o, 0);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            check("arvalid_hold", arvalid_o, 1);
            check("araddr_hold", araddr_o, exp_araddr);
        end
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("arvalid_drop", arvalid_o, 0);
        check("rready_rise", rready_o, 1);
        check("rsp_valid_mid", rsp_valid_o, 0);
        rvalid_i = 1'b1;
        rdata_i  = data;
        rresp_i  = resp;
        tick();
        rvalid_i    = 1'b0;
        req_valid_i = 1'b0;
        check("rsp_valid", rsp_valid_o, 1);
        check("rready_drop", rready_o, 0);
        check("state_hold", state_o, ST_HOLD);
    endtask

    task automatic ack();
        rsp_ack_i = 1'b1;
        tick();
        rsp_ack_i = 1'b0;
        check("ack_valid_low", rsp_valid_o, 0);
        check("ack_err_low", rsp_err_o, 0);
        check("ack_state_idle", state_o, ST_IDLE);
    endtask

    // Directed sequence
    initial begin
        n_checks = 0; n_pass = 0; ar_hs = 0;
        rst = 1'b1; req_valid_i = 1'b0; req_addr_i = 32'd0; rsp_ack_i = 1'b0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 64'd0; rresp_i = 2'b00;
        rlast_i = 1'b1; rid_i = 4'd0;
        tick();
        tick();
        check("rst_state", state_o, ST_IDLE);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_arvalid", arvalid_o, 0);
        check("rst_rready", rready_o, 0);
        check("rst_araddr", araddr_o, 0);
        check("rst_wd", wd_timeout_o, 0);
        check("arlen", arlen_o, 8'd0);
        check("arsize", arsize_o, 3'b011);
        check("arburst", arburst_o, 2'b01);
        check("arid", arid_o, 4'd0);
        rst = 1'b0;

        // Aligned lower word, zero-wait: rsp_valid after the third edge
        fetch(32'h8000_0000, 64'h00100093_00000513, 2'b00, 0, 32'h8000_0000);
        check("lo_data", rsp_data_o, 32'h0000_0513);
        check("lo_err", rsp_err_o, 0);
        ack();

        // Upper word of the same beat
        fetch(32'h8000_0004, 64'h00100093_00000513, 2'b00, 0, 32'h8000_0000);
        check("hi_data", rsp_data_o, 32'h0010_0093);
        check("hi_err", rsp_err_o, 0);

        // Stalled fetch: response held 5 cycles, request ignored, no new AR
        ar_base = ar_hs;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", rsp_valid_o, 1);
            check("stall_data", rsp_data_o, 32'h0010_0093);
            check("stall_noar", arvalid_o, 0);
        end
        req_valid_i = 1'b0;
        check("stall_ar_count", ar_hs - ar_base, 0);
        ack();

        // Next request after ack issues a fresh AR; 4 cycles of AR backpressure
        ar_base = ar_hs;
        fetch(32'h8000_100C, 64'hDEADBEEF_CAFEF00D, 2'b00, 4, 32'h8000_1008);
        check("bp_data", rsp_data_o, 32'hDEAD_BEEF);
        check("bp_ar_count", ar_hs - ar_base, 1);
        ack();

        // SLVERR response
        fetch(32'h8000_1008, 64'hDEADBEEF_CAFEF00D, 2'b10, 1, 32'h8000_1008);
        check("slverr_data", rsp_data_o, 32'hCAFE_F00D);
        check("slverr_err", rsp_err_o, 1);
        ack();

        // Misaligned address: immediate error, no bus access
        ar_base = ar_hs;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0002;
        tick();
        req_valid_i = 1'b0;
        check("mis_valid", rsp_valid_o, 1);
        check("mis_err", rsp_err_o, 1);
        check("mis_data", rsp_data_o, 0);
        check("mis_arvalid", arvalid_o, 0);
        check("mis_state", state_o, ST_HOLD);
        tick();
        check("mis_arvalid2", arvalid_o, 0);
        check("mis_ar_count", ar_hs - ar_base, 0);
        ack();

        // Watchdog: quiet R channel for WD_LIMIT cycles
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0020;
        tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        req_valid_i = 1'b0;
        check("wd_in_r", state_o, ST_R);
        for (int i = 0; i < WD_LIMIT - 1; i++) tick();
        check("wd_before_limit", wd_timeout_o, 0);
        tick();
        check("wd_at_limit", wd_timeout_o, 1);
        check("wd_state_r", state_o, ST_R);
        check("wd_rready", rready_o, 1);
        tick();
        rvalid_i = 1'b1;
        rdata_i  = 64'h11112222_33334444;
        rresp_i  = 2'b00;
        tick();
        rvalid_i = 1'b0;
        check("wd_late_valid", rsp_valid_o, 1);
        check("wd_late_data", rsp_data_o, 32'h3333_4444);
        check("wd_sticky", wd_timeout_o, 1);
        ack();
        check("wd_sticky_idle", wd_timeout_o, 1);

        // Reset while in R drops everything next cycle
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0040;
        tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        req_valid_i = 1'b0;
        check("rr_in_r", state_o, ST_R);
        rst = 1'b1;
        tick();
        check("rr_state", state_o, ST_IDLE);
        check("rr_rready", rready_o, 0);
        check("rr_arvalid", arvalid_o, 0);
        check("rr_araddr", araddr_o, 0);
        check("rr_rsp_valid", rsp_valid_o, 0);
        check("rr_rsp_data", rsp_data_o, 0);
        check("rr_rsp_err", rsp_err_o, 0);
        check("rr_wd", wd_timeout_o, 0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
